// File: rtl/sprite_fetch_ctrl.sv
// Round-robin sprite fetcher: two renderers share one sprite RAM; a burst streams SPR_W*SPR_H pixels, each one cycle after its address.
// A burst occupies N+1 busy cycles; requests outside IDLE are held off (no gnt) until the engine is idle again.
module sprite_fetch_ctrl #(
  parameter int          SPR_W     = 40,
  parameter int          SPR_H     = 40,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [18:0] base0,
  input  logic [18:0] base1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [18:0] ram_addr,
  input  logic [23:0] ram_data,
  output logic        pix_valid,
  output logic [23:0] pix_data,
  output logic        pix_opaque,
  output logic [5:0]  pix_col,
  output logic [5:0]  pix_row,
  output logic        pix_src,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [5:0] COL_LAST = 6'(SPR_W - 1);
  localparam logic [5:0] ROW_LAST = 6'(SPR_H - 1);

  logic [1:0] state;
  logic [5:0] fcol;
  logic [5:0] frow;
  logic       src;
  logic       last_src;
  logic       win;
  logic       fetch_last;

  // On a tie the requester not served last wins; last_src resets to 1 so req0 wins first.
  always_comb begin
    win = req1;
    if (req0 && req1) begin
      win = ~last_src;
    end
  end

  assign fetch_last = (fcol == COL_LAST) && (frow == ROW_LAST);
  assign busy       = (state != IDLE);
  assign pix_data   = pix_valid ? ram_data : 24'd0;
  assign pix_opaque = pix_valid && (ram_data != KEY_COLOR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      fcol      <= 6'd0;
      frow      <= 6'd0;
      src       <= 1'b0;
      last_src  <= 1'b1;
      ram_addr  <= 19'd0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      pix_valid <= 1'b0;
      pix_col   <= 6'd0;
      pix_row   <= 6'd0;
      pix_src   <= 1'b0;
      done      <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          pix_valid <= 1'b0;
          pix_col   <= 6'd0;
          pix_row   <= 6'd0;
          pix_src   <= 1'b0;
          ram_addr  <= 19'd0;
          if (req0 || req1) begin
            state    <= FETCH;
            src      <= win;
            last_src <= win;
            ram_addr <= win ? base1 : base0;
            gnt0     <= ~win;
            gnt1     <= win;
            fcol     <= 6'd0;
            frow     <= 6'd0;
          end
        end
        FETCH: begin
          // The pixel fetched this cycle is presented next cycle, alongside the RAM read data.
          pix_valid <= 1'b1;
          pix_col   <= fcol;
          pix_row   <= frow;
          pix_src   <= src;
          if (fetch_last) begin
            state    <= DRAIN;
            done     <= 1'b1;
            ram_addr <= 19'd0;
            fcol     <= 6'd0;
            frow     <= 6'd0;
          end else begin
            ram_addr <= ram_addr + 19'd1;
            if (fcol == COL_LAST) begin
              fcol <= 6'd0;
              frow <= frow + 6'd1;
            end else begin
              fcol <= fcol + 6'd1;
            end
          end
        end
        DRAIN: begin
          state     <= IDLE;
          pix_valid <= 1'b0;
          pix_col   <= 6'd0;
          pix_row   <= 6'd0;
          pix_src   <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch_ctrl.sv
// Bench for sprite_fetch_ctrl (4x2 sprite): burst table, reset-abort and held-request sequences, then random traffic,
// all compared cycle by cycle against a grant-relative cycle model.
module tb_sprite_fetch_ctrl;

  localparam int          W   = 4;
  localparam int          H   = 2;
  localparam int          N   = W * H;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        Clk;
  logic        Reset_n;
  logic        req0, req1;
  logic [18:0] base0, base1;
  logic        gnt0, gnt1;
  logic [18:0] ram_addr;
  logic [23:0] ram_data;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_opaque;
  logic [5:0]  pix_col, pix_row;
  logic        pix_src;
  logic        busy, done;

  int nchecks = 0;
  int nerr    = 0;
  int mode    = 0;

  // Model: mc = cycles since grant (-1 when idle), plus the latched burst parameters.
  int          mc     = -1;
  bit          m_src  = 1'b0;
  bit          m_last = 1'b1;
  logic [18:0] m_base = 19'd0;

  sprite_fetch_ctrl #(.SPR_W(W), .SPR_H(H), .KEY_COLOR(KEY)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req0(req0), .req1(req1), .base0(base0), .base1(base1),
    .gnt0(gnt0), .gnt1(gnt1), .ram_addr(ram_addr), .ram_data(ram_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_opaque(pix_opaque),
    .pix_col(pix_col), .pix_row(pix_row), .pix_src(pix_src), .busy(busy), .done(done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [23:0] mem_word(input logic [18:0] a, input int md);
    case (md)
      0:       return {a[7:0], ~a[7:0], a[15:8]} ^ 24'h3C5A96;
      1:       return a[0] ? 24'h00FF00 : KEY;
      default: return (a[1:0] == 2'b00) ? KEY : {a[18:11], a[10:3], 8'h42};
    endcase
  endfunction

  always @(posedge Clk) ram_data <= mem_word(ram_addr, mode);

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mc     = -1;
      m_last = 1'b1;
    end else if (mc < 0) begin
      if (req0 || req1) begin
        m_src  = (req0 && req1) ? ~m_last : req1;
        m_last = m_src;
        m_base = m_src ? base1 : base0;
        mc     = 0;
      end
    end else begin
      mc = (mc == N) ? -1 : mc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic [18:0] ea;
    logic [23:0] ed;
    int k;
    bit pv;
    ea = (mc >= 0 && mc < N) ? m_base + 19'(mc) : 19'd0;
    pv = (mc >= 1);
    chk("busy", 32'(busy), 32'(mc >= 0));
    chk("gnt0", 32'(gnt0), 32'(mc == 0 && !m_src));
    chk("gnt1", 32'(gnt1), 32'(mc == 0 && m_src));
    chk("ram_addr", 32'(ram_addr), 32'(ea));
    chk("pix_valid", 32'(pix_valid), 32'(pv));
    chk("done", 32'(done), 32'(mc == N));
    if (pv) begin
      k  = mc - 1;
      ed = mem_word(m_base + 19'(k), mode);
      chk("pix_data", 32'(pix_data), 32'(ed));
      chk("pix_opaque", 32'(pix_opaque), 32'(ed != KEY));
      chk("pix_col", 32'(pix_col), 32'(k % W));
      chk("pix_row", 32'(pix_row), 32'(k / W));
      chk("pix_src", 32'(pix_src), 32'(m_src));
    end else begin
      chk("pix_opaque_idle", 32'(pix_opaque), 32'd0);
    end
  endtask

  task automatic check_zero();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_pix_opaque", 32'(pix_opaque), 32'd0);
    chk("rst_col_row", 32'({pix_col, pix_row}), 32'd0);
    chk("rst_pix_src", 32'(pix_src), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
  endtask

  // Requesters drop req the cycle after their grant.
  task automatic step();
    @(negedge Clk);
    check_cycle();
    if (mc == 1) begin
      if (m_src) req1 = 1'b0;
      else       req0 = 1'b0;
    end
  endtask

  task automatic burst(input bit exp_win, input logic [18:0] exp_addr, input int raise1_at, input logic [18:0] b1);
    int g, nb, nv, nd;
    g = 0;
    while (mc != 0 && g < 40) begin
      step();
      g++;
    end
    chk("grant_seen", 32'(mc == 0), 32'd1);
    chk("gnt_winner", 32'({gnt1, gnt0}), exp_win ? 32'd2 : 32'd1);
    chk("first_addr", 32'(ram_addr), 32'(exp_addr));
    nb = 0; nv = 0; nd = 0; g = 0;
    while (mc != -1 && g < 40) begin
      nb += int'(busy);
      nv += int'(pix_valid);
      nd += int'(done);
      if (mc == raise1_at) begin
        req1  = 1'b1;
        base1 = b1;
      end
      step();
      g++;
    end
    chk("busy_cycles", 32'(nb), 32'(N + 1));
    chk("pixel_count", 32'(nv), 32'(N));
    chk("done_pulses", 32'(nd), 32'd1);
  endtask

  typedef struct {
    bit          r0, r1;
    logic [18:0] b0, b1;
    int          md;
    bit          exp_win;
    logic [18:0] exp_addr;
  } vec_t;

  vec_t vt[5];

  initial begin
    int g;
    vt[0] = '{r0:1, r1:1, b0:19'h00100, b1:19'h00300, md:1, exp_win:0, exp_addr:19'h00100};
    vt[1] = '{r0:0, r1:1, b0:19'h00100, b1:19'h00300, md:0, exp_win:1, exp_addr:19'h00300};
    vt[2] = '{r0:1, r1:1, b0:19'h00010, b1:19'h00020, md:2, exp_win:0, exp_addr:19'h00010};
    vt[3] = '{r0:0, r1:1, b0:19'h00000, b1:19'h7FFFE, md:0, exp_win:1, exp_addr:19'h7FFFE};
    vt[4] = '{r0:1, r1:0, b0:19'h00100, b1:19'h00000, md:1, exp_win:0, exp_addr:19'h00100};

    Reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; base0 = 19'd0; base1 = 19'd0;
    #12;
    check_zero();
    @(negedge Clk);
    Reset_n = 1'b1;

    // Table: ties, a held loser, address wrap and the opaque pattern.
    for (int i = 0; i < 5; i++) begin
      if (vt[i].r0) req0 = 1'b1;
      if (vt[i].r1) req1 = 1'b1;
      base0 = vt[i].b0;
      base1 = vt[i].b1;
      mode  = vt[i].md;
      burst(vt[i].exp_win, vt[i].exp_addr, -1, 19'd0);
    end

    // Reset in FETCH cycle 3 aborts the burst; a fresh request is served in full afterwards.
    req0 = 1'b1; base0 = 19'h00040; mode = 0;
    g = 0;
    while (mc != 3 && g < 40) begin
      step();
      g++;
    end
    chk("reached_cycle3", 32'(mc == 3), 32'd1);
    Reset_n = 1'b0;
    #1;
    check_zero();
    step();
    Reset_n = 1'b1;
    req0 = 1'b1; base0 = 19'h00080;
    burst(1'b0, 19'h00080, -1, 19'd0);

    // req1 raised mid-burst is only granted once the engine is idle.
    req0 = 1'b1; base0 = 19'h01234; mode = 1;
    burst(1'b0, 19'h01234, 2, 19'h00555);
    burst(1'b1, 19'h00555, -1, 19'd0);

    for (int c = 0; c < 400; c++) begin
      if (!req0 && $urandom_range(3) == 0) begin
        req0  = 1'b1;
        base0 = 19'($urandom);
      end
      if (!req1 && $urandom_range(3) == 0) begin
        req1  = 1'b1;
        base1 = 19'($urandom);
      end
      if (mc == -1 && $urandom_range(1) == 0) mode = int'($urandom_range(2));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule

// File: doc/sprite_fetch_ctrl.md
SPRITE_FETCH_CTRL -- requirements
Module: sprite_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter SPR_W, default 40, meaning sprite width in pixels.
REQ-002 The block SHALL have parameter SPR_H, default 40, meaning sprite height in pixels.
REQ-003 The block SHALL have parameter KEY_COLOR, default 24'hFF00FF, meaning transparent colour value.
REQ-004 The block SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports req0 and req1, input, 1 each, fetch requests (0 = player ship renderer, 1 = enemy renderer).
REQ-007 The block SHALL have ports base0 and base1, input, 19 each, sprite start address in the sprite RAM per requester.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 each, one-cycle acceptance pulses.
REQ-009 The block SHALL have port ram_addr, output, 19, registered read address to the sprite RAM read port.
REQ-010 The block SHALL have port ram_data, input, 24, sprite RAM read data (1-cycle synchronous read latency).
REQ-011 The block SHALL have ports pix_valid (1), pix_data (24), pix_opaque (1), pix_col (6), pix_row (6) and pix_src (1), all outputs, forming the pixel stream.
REQ-012 The block SHALL have ports busy and done, output, 1 each; busy = not IDLE; done = last-pixel pulse.

Function
REQ-013 The FSM SHALL have states IDLE, FETCH and DRAIN.
REQ-014 In IDLE with any req sampled high at a clock edge, the FSM SHALL move to FETCH, latch the winner's base and id, and assert the winner's gnt for exactly that first FETCH cycle (cycle 0).
REQ-015 Arbitration SHALL be round-robin: with both req high, the requester not served last wins; after reset, req0 wins the first tie.
REQ-016 Req asserted outside IDLE SHALL be ignored (no gnt); requesters hold req until gnt and drop it the cycle after gnt.
REQ-017 In FETCH cycle k (k = 0..N-1, N = SPR_W*SPR_H), ram_addr SHALL equal (base + k) mod 2^19; address wrap-around is silent.
REQ-018 In cycle k+1, pix_valid SHALL be 1 and pix_data SHALL equal ram_data (the word at base+k).
REQ-019 pix_col SHALL equal k mod SPR_W and pix_row SHALL equal k div SPR_W, both maintained by counters with no divider.
REQ-020 pix_src SHALL equal the served requester id for every pixel of the burst.
REQ-021 pix_opaque SHALL be 1 exactly when pix_data differs from KEY_COLOR, and 0 whenever pix_valid is 0.
REQ-022 After cycle N-1 the FSM SHALL enter DRAIN for one cycle (cycle N), then return to IDLE.
REQ-023 done SHALL pulse in cycle N, coincident with the last pixel (col SPR_W-1, row SPR_H-1).
REQ-024 The minimum gap between consecutive bursts SHALL be one IDLE cycle; total occupancy per burst is N+1 busy cycles.
REQ-025 In IDLE, ram_addr SHALL be 0, and pix_valid, gnt0, gnt1 and done SHALL be 0.

Reset
REQ-026 Reset_n low SHALL immediately force state IDLE, all outputs to 0, all counters to 0, and the round-robin pointer to favour req0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no further pix_valid or done; after release, the block accepts requests from the following edge.

Verification
REQ-028 Use SPR_W = 4 and SPR_H = 2 (N = 8), req0 = 1, base0 = 0x100 -> gnt0 pulse; ram_addr 0x100..0x107; 8 pix_valid cycles with col 0..3 / row 0..1; done with the 8th pixel; busy for 9 cycles.
REQ-029 With req0 and req1 both high after reset -> gnt0 first; req1 held -> gnt1 one IDLE cycle after the first burst's DRAIN; a second tie -> gnt0.
REQ-030 With base1 = 0x7FFFE and N = 8 -> ram_addr sequence 0x7FFFE, 0x7FFFF, 0x00000..0x00005; pix_src = 1 for every pixel.
REQ-031 With RAM words alternating 24'hFF00FF and 24'h00FF00 -> pix_opaque pattern 0,1,0,1,... aligned with pix_valid.
REQ-032 Reset_n pulsed low in FETCH cycle 3 -> outputs 0 immediately, no done; a new req0 afterwards is granted with a full 8-pixel burst starting at col 0.
REQ-033 req1 raised during FETCH for req0 -> no gnt1 until IDLE; then gnt1 is issued and ram_addr starts at base1.
